// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// State enum, default register map and the source-count ceiling.
package irq_ctrl_pkg;

  localparam int NSRC_MAX = 8;
  localparam int VEC_W    = 3;

  localparam logic [7:0] DEF_A_IFR   = 8'h16;
  localparam logic [7:0] DEF_A_IMSK  = 8'h6f;
  localparam logic [7:0] DEF_A_ISTAT = 8'h17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner selection: first pending source found when scanning
// upward from a start index, wrapping at NSRC.
module irq_prio_sel
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = NSRC_MAX
) (
  input  logic [NSRC-1:0]  pending,
  input  logic [VEC_W-1:0] start,
  output logic             valid,
  output logic [VEC_W-1:0] index
);

  logic [2*NSRC-1:0] doubled;
  logic [NSRC-1:0]   rotated;

  // Rotating a doubled copy puts the start source at bit 0, so a plain
  // lowest-bit scan yields the wrap-around search order.
  assign doubled = {pending, pending};
  assign rotated = NSRC'(doubled >> start);

  always_comb begin
    int hit;
    hit   = 0;
    valid = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        valid = 1'b1;
        hit   = k;
      end
    end
    index = VEC_W'((int'(start) + hit) % NSRC);
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected flags, mask, status and a REQ/DONE
// handshake to the CPU. Define IRQ_CTRL_ROUND_ROBIN_EN for round-robin grants.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int         NSRC    = NSRC_MAX,
  parameter logic [7:0] A_IFR   = DEF_A_IFR,
  parameter logic [7:0] A_IMSK  = DEF_A_IMSK,
  parameter logic [7:0] A_ISTAT = DEF_A_ISTAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write,
  input  logic [7:0]      addr,
  input  logic [7:0]      wdata,
  input  logic            read,
  output logic [7:0]      rdata,
  input  logic [NSRC-1:0] irq_src,
  input  logic            status_reg_interrupt_enable,
  output logic            interrupt_request,
  output logic [2:0]      interrupt_vector,
  input  logic            interrupt_executed
);

  state_t            state;
  logic [NSRC-1:0]   ifr;
  logic [NSRC-1:0]   imsk;
  logic [NSRC-1:0]   src_prev;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   ifr_clr;
  logic [NSRC-1:0]   ifr_next;
  logic [NSRC-1:0]   pending;
  logic [VEC_W-1:0]  sel_start;
  logic [VEC_W-1:0]  sel_index;
  logic              sel_valid;

  assign rise    = irq_src & ~src_prev;
  assign pending = ifr & imsk;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [VEC_W-1:0] rr_ptr;
  assign sel_start = rr_ptr;
`else
  assign sel_start = '0;
`endif

  irq_prio_sel #(.NSRC(NSRC)) u_sel (
    .pending (pending),
    .start   (sel_start),
    .valid   (sel_valid),
    .index   (sel_index)
  );

  // A fresh edge always wins over a clear landing in the same cycle.
  always_comb begin
    ifr_clr = '0;
    if (write && addr == A_IFR)
      ifr_clr = wdata[NSRC-1:0];
    if (state == REQ && interrupt_executed)
      ifr_clr = ifr_clr | (NSRC'(1) << interrupt_vector);
    ifr_next = (ifr & ~ifr_clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ifr      <= '0;
      imsk     <= '0;
      src_prev <= '0;
    end else begin
      ifr      <= ifr_next;
      src_prev <= irq_src;
      if (write && addr == A_IMSK)
        imsk <= wdata[NSRC-1:0];
    end
  end

  // Once granted, the request is held until the CPU acknowledges it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      interrupt_request <= 1'b0;
      interrupt_vector  <= '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      rr_ptr            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (status_reg_interrupt_enable && sel_valid) begin
            state             <= REQ;
            interrupt_request <= 1'b1;
            interrupt_vector  <= sel_index;
          end
        end
        REQ: begin
          if (interrupt_executed) begin
            state             <= DONE;
            interrupt_request <= 1'b0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            rr_ptr <= (interrupt_vector == VEC_W'(NSRC - 1)) ? '0
                                                             : interrupt_vector + 3'd1;
`endif
          end
        end
        DONE: begin
          if (!interrupt_executed)
            state <= IDLE;
        end
        default: begin
          state             <= IDLE;
          interrupt_request <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (read) begin
      if (addr == A_IFR)
        rdata = 8'(ifr);
      else if (addr == A_IMSK)
        rdata = 8'(imsk);
      else if (addr == A_ISTAT)
        rdata = {(state != IDLE), 4'b0000, interrupt_vector};
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl; honours IRQ_CTRL_ROUND_ROBIN_EN when defined.
// A flag/mask/phase reference model predicts grants; a monitor checks them.
module tb_irq_ctrl;

  localparam int         N       = 8;
  localparam logic [7:0] A_IFR   = 8'h16;
  localparam logic [7:0] A_IMSK  = 8'h6f;
  localparam logic [7:0] A_ISTAT = 8'h17;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         write = 1'b0;
  logic         read = 1'b0;
  logic [7:0]   addr = 8'h00;
  logic [7:0]   wdata = 8'h00;
  logic [N-1:0] irq_src = '0;
  logic         enable = 1'b0;
  logic         executed = 1'b0;
  logic [7:0]   rdata;
  logic         interrupt_request;
  logic [2:0]   interrupt_vector;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_grants[$];
  int grant_log[$];

  bit m_flag[N];
  bit m_mask[N];
  bit m_prev[N];
  int m_phase = 0;
  int m_vec = 0;
  int m_ptr = 0;
  bit prev_req = 1'b0;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(N), .A_IFR(A_IFR), .A_IMSK(A_IMSK), .A_ISTAT(A_ISTAT)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .write                       (write),
    .addr                        (addr),
    .wdata                       (wdata),
    .read                        (read),
    .rdata                       (rdata),
    .irq_src                     (irq_src),
    .status_reg_interrupt_enable (enable),
    .interrupt_request           (interrupt_request),
    .interrupt_vector            (interrupt_vector),
    .interrupt_executed          (executed)
  );

  function automatic int pick_winner();
    int start;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (m_flag[(start + k) % N] && m_mask[(start + k) % N])
        return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == A_IFR) begin
      for (int i = 0; i < N; i++) v[i] = m_flag[i];
    end else if (a == A_IMSK) begin
      for (int i = 0; i < N; i++) v[i] = m_mask[i];
    end else if (a == A_ISTAT) begin
      v = {(m_phase != 0), 4'b0000, 3'(m_vec)};
    end
    return v;
  endfunction

  // Reference model: phase 0 idle, 1 requesting, 2 waiting for ack release.
  always @(posedge clk) begin : ref_model
    bit rise[N];
    bit clr[N];
    int w;
    int old_phase;
    int old_vec;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_flag[i] = 1'b0; m_mask[i] = 1'b0; m_prev[i] = 1'b0;
      end
      m_phase = 0; m_vec = 0; m_ptr = 0;
      exp_grants.delete();
    end else begin
      old_phase = m_phase;
      old_vec   = m_vec;
      for (int i = 0; i < N; i++) begin
        rise[i] = irq_src[i] && !m_prev[i];
        clr[i]  = write && (addr == A_IFR) && wdata[i];
      end
      if (old_phase == 1 && executed) clr[old_vec] = 1'b1;
      case (old_phase)
        0: if (enable) begin
             w = pick_winner();
             if (w >= 0) begin
               m_phase = 1; m_vec = w; exp_grants.push_back(w);
             end
           end
        1: if (executed) begin m_phase = 2; m_ptr = (old_vec + 1) % N; end
        default: if (!executed) m_phase = 0;
      endcase
      for (int i = 0; i < N; i++) begin
        m_flag[i] = (m_flag[i] && !clr[i]) || rise[i];
        m_prev[i] = irq_src[i];
        if (write && addr == A_IMSK) m_mask[i] = wdata[i];
      end
    end
  end

  // Monitor: request level every cycle, grant vector on every rising request.
  always @(posedge clk) begin
    #1;
    n_cmp++;
    if (interrupt_request !== (m_phase == 1)) begin
      n_bad++;
      $display("[TB] FAIL request_level: got %b required %b at %0t", interrupt_request, (m_phase == 1), $time);
    end
    if (interrupt_request === 1'b1 && !prev_req) begin
      grant_log.push_back(int'(interrupt_vector));
      n_cmp++;
      if (exp_grants.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL grant_vector: got %0d required no grant at %0t", interrupt_vector, $time);
      end else begin
        int e;
        e = exp_grants.pop_front();
        if (interrupt_vector !== 3'(e)) begin
          n_bad++;
          $display("[TB] FAIL grant_vector: got %0d required %0d at %0t", interrupt_vector, e, $time);
        end
      end
    end else if (interrupt_request === 1'b1) begin
      n_cmp++;
      if (interrupt_vector !== 3'(m_vec)) begin
        n_bad++;
        $display("[TB] FAIL vector_stable: got %0d required %0d at %0t", interrupt_vector, m_vec, $time);
      end
    end
    prev_req = (interrupt_request === 1'b1);
  end

  task automatic applyStimulus(input logic [N-1:0] src, input logic en, input logic ex,
                               input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    irq_src = src; enable = en; executed = ex; write = wr; addr = a; wdata = d; read = 1'b0;
  endtask

  // Only used in cycles with write=0, since it borrows the address bus.
  task automatic checkOutput(input string name, input logic [7:0] a, input logic [7:0] expv);
    read = 1'b1; addr = a;
    #1;
    n_cmp++;
    if (rdata !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: rdata=%h required %h", name, rdata, expv);
    end
    read = 1'b0;
  endtask

  task automatic checkReq(input string name, input logic er, input logic [2:0] ev);
    n_cmp++;
    if (interrupt_request !== er || (er && interrupt_vector !== ev)) begin
      n_bad++;
      $display("[TB] FAIL %s: req=%b vec=%0d required req=%b vec=%0d", name,
               interrupt_request, interrupt_vector, er, ev);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b0; irq_src = '0; enable = 1'b0; executed = 1'b0; write = 1'b0; read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    grant_log.delete();
  endtask

  initial begin
    int exp_seq[4];
    $display("[TB] start");
    resetDut();
    checkReq("reset_req", 1'b0, 3'd0);
    checkOutput("reset_ifr", A_IFR, 8'h00);
    checkOutput("reset_imsk", A_IMSK, 8'h00);
    checkOutput("reset_istat", A_ISTAT, 8'h00);

    // Single source, two-cycle request latency, clear on acknowledge.
    applyStimulus('0, 1, 0, 1, A_IMSK, 8'h07);
    applyStimulus(8'h02, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkOutput("s1_ifr_set", A_IFR, 8'h02);
    checkReq("s1_not_yet", 1'b0, 3'd0);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s1_req", 1'b1, 3'd1);
    applyStimulus('0, 1, 1, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkOutput("s1_ifr_clear", A_IFR, 8'h00);

    // Simultaneous sources 0 and 2.
    resetDut();
    applyStimulus('0, 1, 0, 1, A_IMSK, 8'hFF);
    applyStimulus(8'h05, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s2_first", 1'b1, 3'd0);
    applyStimulus('0, 1, 1, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkOutput("s2_istat_done", A_ISTAT, 8'h80);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s2_second", 1'b1, 3'd2);
    applyStimulus('0, 1, 1, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);

    // Masked-out flag waits for the mask.
    resetDut();
    applyStimulus(8'h08, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkOutput("s3_ifr", A_IFR, 8'h08);
    checkReq("s3_masked", 1'b0, 3'd0);
    applyStimulus('0, 1, 0, 1, A_IMSK, 8'h08);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s3_still_idle", 1'b0, 3'd0);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s3_req", 1'b1, 3'd3);
    applyStimulus('0, 1, 1, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);

    // Global enable gating and write-1-to-clear.
    resetDut();
    applyStimulus('0, 0, 0, 1, A_IMSK, 8'h01);
    applyStimulus(8'h01, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s4_disabled", 1'b0, 3'd0);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s4_enabled", 1'b1, 3'd0);
    applyStimulus('0, 1, 1, 0, 8'h00, 8'h00);
    applyStimulus('0, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus(8'hF0, 0, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("s4_ifr_set", A_IFR, 8'hF0);
    applyStimulus('0, 0, 0, 1, A_IFR, 8'hFF);
    applyStimulus('0, 0, 0, 0, 8'h00, 8'h00);
    checkOutput("s4_ifr_w1c", A_IFR, 8'h00);
    checkOutput("s4_istat_idle", A_ISTAT, 8'h00);

    // Reset in the middle of a handshake.
    resetDut();
    applyStimulus('0, 1, 0, 1, A_IMSK, 8'hFF);
    applyStimulus(8'h04, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s6_req", 1'b1, 3'd2);
    rst = 1'b0;
    applyStimulus('0, 1, 0, 0, 8'h00, 8'h00);
    checkReq("s6_aborted", 1'b0, 3'd0);
    checkOutput("s6_ifr", A_IFR, 8'h00);
    checkOutput("s6_istat", A_ISTAT, 8'h00);
    rst = 1'b1;

    // Sources 0 and 1 re-pulsed continuously with a prompt CPU.
    resetDut();
    applyStimulus('0, 1, 0, 1, A_IMSK, 8'h03);
    for (int c = 0; c < 40; c++)
      applyStimulus((c % 2 == 0) ? N'(3) : N'(0), 1, interrupt_request, 0, 8'h00, 8'h00);
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    n_cmp++;
    if (grant_log.size() < 4) begin
      n_bad++;
      $display("[TB] FAIL s5_grant_count: got %0d required at least 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (grant_log[i] != exp_seq[i]) begin
          n_bad++;
          $display("[TB] FAIL s5_grant_%0d: got %0d required %0d", i, grant_log[i], exp_seq[i]);
        end
      end
    end

    // Random traffic against the reference model.
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic wr;
      logic [7:0] a;
      logic [7:0] ra;
      r  = $urandom_range(0, 15);
      wr = 1'b0;
      a  = 8'h00;
      if (r == 0) begin wr = 1'b1; a = A_IMSK; end
      else if (r == 1) begin wr = 1'b1; a = A_IFR; end
      else if (r == 2) begin wr = 1'b1; a = 8'($urandom); end
      applyStimulus(N'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    wr, a, 8'($urandom));
      rst = ($urandom_range(0, 249) != 0);
      if (!wr && r < 9) begin
        case ($urandom_range(0, 3))
          0: ra = A_IFR;
          1: ra = A_IMSK;
          2: ra = A_ISTAT;
          default: ra = 8'($urandom);
        endcase
        checkOutput("rand_read", ra, exp_read(ra));
      end
    end
    rst = 1'b1;
    repeat (4) applyStimulus('0, 0, 0, 0, 8'h00, 8'h00);

    n_cmp++;
    if (exp_grants.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL grants_outstanding: got %0d required 0", exp_grants.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 8, SHALL set the number of interrupt sources (range 2..8).
REQ-002 Parameter A_IFR, default 8'h16, SHALL set the flag register address.
REQ-003 Parameter A_IMSK, default 8'h6f, SHALL set the mask register address.
REQ-004 Parameter A_ISTAT, default 8'h17, SHALL set the read-only status register address.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: synchronous, active-low (asserted when 0).
REQ-007 write  input  1  SHALL be the register write strobe, sampled at clk rise.
REQ-008 addr  input  8  SHALL be the register address.
REQ-009 wdata  input  8  SHALL be the register write data.
REQ-010 read  input  1  SHALL be the register read enable.
REQ-011 rdata  output  8  SHALL be the register read data.
REQ-012 irq_src  input  NSRC  SHALL be the event lines from timers and peripherals (bit i = source i).
REQ-013 status_reg_interrupt_enable  input  1  SHALL be the CPU global interrupt enable.
REQ-014 interrupt_request  output  1  SHALL be the request to the CPU.
REQ-015 interrupt_vector  output  3  SHALL be the index of the granted source; stable while interrupt_request is high.
REQ-016 interrupt_executed  input  1  SHALL be the CPU acknowledge.

Function
REQ-017 A source rising edge (sampled 0 then 1 on consecutive clk rises) SHALL set IFR[i] at that same clk edge.
REQ-018 IFR SHALL be write-1-to-clear; a set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-019 IMSK SHALL be read/write; bits at or above NSRC SHALL read 0 in IFR and IMSK.
REQ-020 ISTAT SHALL read {busy, 4'b0, interrupt_vector}; busy = 1 when the FSM is not in IDLE.
REQ-021 rdata SHALL be combinational: the selected register when read=1 and addr matches, else 8'h00.
REQ-022 The FSM SHALL have states IDLE, REQ and DONE.
REQ-023 IDLE->REQ SHALL occur when status_reg_interrupt_enable=1 and (IFR & IMSK) != 0; the winner SHALL be latched into interrupt_vector.
REQ-024 In REQ, interrupt_request SHALL be 1; changes to the mask, enable or flags SHALL NOT withdraw the request.
REQ-025 REQ->DONE SHALL occur when interrupt_executed is sampled 1; at that edge IFR[vector] SHALL clear, unless a new edge on that source arrives in the same cycle, in which case the bit SHALL stay set.
REQ-026 DONE->IDLE SHALL occur when interrupt_executed is sampled 0; interrupt_request SHALL be 0 in DONE.
REQ-027 Latency: interrupt_request SHALL rise after the second clk rise following the edge that sets the flag, when enabled, masked-in and idle.
REQ-028 Default arbitration SHALL be fixed priority, with the lowest index winning.

Reset
REQ-029 While rst=0, at the clk edge: IFR=0, IMSK=0, edge-detect history=0, state=IDLE, interrupt_request=0, interrupt_vector=0, round-robin pointer=0.
REQ-030 Reset mid-handshake SHALL abort the request with no flag retained.

Configuration
REQ-031 When macro IRQ_CTRL_ROUND_ROBIN_EN is defined, arbitration SHALL be round-robin: the search starts at (last granted + 1) mod NSRC, and the pointer updates on each REQ->DONE.
REQ-032 When IRQ_CTRL_ROUND_ROBIN_EN is undefined, arbitration SHALL be fixed priority per REQ-028, and no pointer register SHALL exist.

Structure
REQ-033 Package irq_ctrl_pkg SHALL hold the FSM state enum, the default address constants and the NSRC maximum.
REQ-034 Sub-module irq_prio_sel SHALL hold the combinational winner selection (pending vector and start index in; valid and index out).

Verification
REQ-035 Scenario 1: IMSK=8'h07, enable=1, pulse irq_src[1] -> IFR reads 8'h02, request rises 2 cycles later with vector=1; executed=1 -> IFR reads 8'h00.
REQ-036 Scenario 2: irq_src[0] and irq_src[2] rise together, fixed mode -> vector 0 first, then vector 2 after the DONE->IDLE transition.
REQ-037 Scenario 3: IMSK=8'h00, pulse irq_src[3] -> IFR=8'h08 and no request; write IMSK=8'h08 -> request with vector=3.
REQ-038 Scenario 4: enable=0 with a pending masked-in flag -> no request; raise enable -> request within 1 cycle; write IFR=8'hFF while idle -> all flags clear.
REQ-039 Scenario 5: round-robin build, sources 0 and 1 re-pulsed continuously -> grants alternate 0,1,0,1.
REQ-040 Scenario 6: rst=0 during REQ -> request=0 and IFR=0 on the next clk edge; ISTAT reads 8'h00.
